// File: rtl/ngs_boot_core_gpio_pkg.sv
// Register offsets shared by the boot-core GPIO block and its input edge-capture stage.
// The GPIO block relies on offsets 0-2 keeping these values.
package ngs_boot_core_gpio_pkg;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_EDGE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_RISE  = 3'd3;
    localparam logic [2:0] ADDR_FALL  = 3'd4;
    localparam logic [2:0] ADDR_DBLIM = 3'd5;

endpackage

// File: rtl/ngs_boot_core_gpio_debounce.sv
// Single-bit conditioner: SYNC_STAGES-deep synchroniser followed by a counting debouncer.
// o_upd pulses for the one cycle in which o_stable takes the synchronised value.
module ngs_boot_core_gpio_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_BITS     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_pin,
    input  logic [DB_BITS-1:0] i_lim_m1,
    output logic               o_sync,
    output logic               o_stable,
    output logic               o_upd
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_BITS-1:0]     r_cnt;
    logic                   r_stable;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = w_sync ^ r_stable;
    // ">=" so that lowering the limit mid-count releases a count already past it
    assign w_hit  = (r_cnt >= i_lim_m1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_diff) begin
            r_cnt    <= '0;
        end else if (w_hit) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_sync   = w_sync;
    assign o_stable = r_stable;
    assign o_upd    = w_diff & w_hit;

endmodule

// File: rtl/ngs_boot_core_gpio_edgecap.sv
// GPIO input conditioning: per-bit sync/debounce, edge capture into a W1C register
// with maskable level interrupt, and a 3-bit-address Avalon-MM slave.
module ngs_boot_core_gpio_edgecap
    import ngs_boot_core_gpio_pkg::*;
#(
    parameter int WIDTH       = 30,
    parameter int SYNC_STAGES = 2,
    parameter int DB_BITS     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] stable_out,
    output logic             irq
);

    logic [WIDTH-1:0]   r_edge_cap;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [WIDTH-1:0]   r_rise_en;
    logic [WIDTH-1:0]   r_fall_en;
    logic [DB_BITS-1:0] r_db_limit;
    logic [31:0]        r_readdata;

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_upd;
    logic [WIDTH-1:0]   w_set;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_wdata;
    logic [DB_BITS-1:0] w_lim_m1;
    logic [31:0]        w_rd_mux;
    logic               w_wr;
    logic               w_unused_wdata;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    // Upper write-data bits are architecturally ignored
    assign w_unused_wdata = ^writedata;

    // Effective limit L = max(db_limit,1); debouncers compare against L-1
    assign w_lim_m1 = (r_db_limit == '0) ? '0 : (r_db_limit - 1'b1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            ngs_boot_core_gpio_debounce #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_BITS     (DB_BITS)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_pin    (pin_in[gi]),
                .i_lim_m1 (w_lim_m1),
                .o_sync   (w_sync[gi]),
                .o_stable (w_stable[gi]),
                .o_upd    (w_upd[gi])
            );
        end
    endgenerate

    assign w_set = (w_upd & w_sync & r_rise_en) | (w_upd & ~w_sync & r_fall_en);
    assign w_clr = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_db_limit <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_MASK:  r_irq_mask <= w_wdata;
                ADDR_RISE:  r_rise_en  <= w_wdata;
                ADDR_FALL:  r_fall_en  <= w_wdata;
                ADDR_DBLIM: r_db_limit <= writedata[DB_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:  w_rd_mux[WIDTH-1:0]   = w_stable;
            ADDR_EDGE:  w_rd_mux[WIDTH-1:0]   = r_edge_cap;
            ADDR_MASK:  w_rd_mux[WIDTH-1:0]   = r_irq_mask;
            ADDR_RISE:  w_rd_mux[WIDTH-1:0]   = r_rise_en;
            ADDR_FALL:  w_rd_mux[WIDTH-1:0]   = r_fall_en;
            ADDR_DBLIM: w_rd_mux[DB_BITS-1:0] = r_db_limit;
            default:    w_rd_mux = '0;
        endcase
    end

    // Read port runs every cycle so a same-cycle write is seen as the old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata   = r_readdata;
    assign stable_out = w_stable;
    assign irq        = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_ngs_boot_core_gpio_edgecap.sv
// Directed bench for the GPIO edge-capture stage: debounce latency, glitch rejection,
// W1C/set priority, edge enables, irq masking and asynchronous reset.
module tb_ngs_boot_core_gpio_edgecap;

    localparam int WIDTH = 30;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] pin_in;
    logic             chipselect;
    logic [2:0]       address;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] stable_out;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ngs_boot_core_gpio_edgecap #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .DB_BITS     (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin_in     (pin_in),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .stable_out (stable_out),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(posedge clk);
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic        seen;

    initial begin
        reset_n    = 1'b0;
        pin_in     = '0;
        chipselect = 1'b0;
        address    = '0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), rd);
            chk($sformatf("rst_rd_a%0d", a), rd, 32'h0);
        end
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_stable", 32'(stable_out), 32'h0);

        // Read-only / unmapped addresses ignore writes; db_limit keeps low 8 bits
        bus_wr(3'd0, 32'hFFFF_FFFF);
        bus_rd(3'd0, rd);
        chk("ro_data", rd, 32'h0);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, rd);
        chk("unmapped_a6", rd, 32'h0);
        bus_wr(3'd5, 32'h0000_0104);
        bus_rd(3'd5, rd);
        chk("dblim_trunc", rd, 32'h4);
        bus_wr(3'd3, 32'h1);

        // irq_mask write with a same-cycle read returns the old value
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = 32'h1;
        @(posedge clk);
        #1 rd = readdata;
        chk("rdwr_old", rd, 32'h0);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Rising edge on bit 0 with L=4: stable exactly 2+4 cycles after the pin edge
        pin_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("lat_stable_c5", 32'(stable_out[0]), 32'h0);
        chk("lat_irq_c5", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_stable_c6", 32'(stable_out[0]), 32'h1);
        chk("lat_irq_c6", 32'(irq), 32'h1);
        bus_rd(3'd1, rd);
        chk("edge_rise0", rd, 32'h1);

        // W1C clears and drops irq
        bus_wr(3'd1, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);
        bus_rd(3'd1, rd);
        chk("w1c_edge", rd, 32'h0);
        @(negedge clk);
        pin_in[0] = 1'b0;
        repeat (10) @(posedge clk);
        bus_rd(3'd1, rd);
        chk("fall0_nocap", rd, 32'h0);

        // New rising edge lands on the clearing write's edge: set wins
        @(negedge clk);
        pin_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        bus_wr(3'd1, 32'h1);
        bus_rd(3'd1, rd);
        chk("set_wins", rd, 32'h1);
        chk("set_wins_irq", 32'(irq), 32'h1);
        bus_wr(3'd1, 32'h1);

        // 3-cycle glitch on bit 3 is rejected
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pin_in[3] = (k < 3);
            seen |= stable_out[3];
        end
        chk("glitch3_stable", 32'(seen), 32'h0);
        bus_rd(3'd1, rd);
        chk("glitch3_edge", rd, 32'h0);

        // 4-cycle pulse passes; only the falling edge is enabled on bit 3
        bus_wr(3'd4, 32'h8);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pin_in[3] = (k < 4);
            seen |= stable_out[3];
        end
        chk("pulse4_seen", 32'(seen), 32'h1);
        chk("pulse4_back", 32'(stable_out[3]), 32'h0);
        bus_rd(3'd1, rd);
        chk("pulse4_edge", rd, 32'h8);
        chk("pulse4_irq", 32'(irq), 32'h0);

        // Per-bit rise/fall enables with irq masked
        @(negedge clk);
        pin_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, rd);
        chk("clr_all", rd, 32'h0);
        bus_wr(3'd2, 32'h0);
        bus_wr(3'd3, 32'h5);
        bus_wr(3'd4, 32'h2);
        @(negedge clk);
        pin_in[2:0] = 3'b111;
        repeat (12) @(negedge clk);
        pin_in[2:0] = 3'b000;
        repeat (12) @(negedge clk);
        bus_rd(3'd1, rd);
        chk("en_edge", rd, 32'h7);
        chk("en_irq_masked", 32'(irq), 32'h0);
        bus_wr(3'd2, 32'hFFFF_FFFF);
        bus_rd(3'd2, rd);
        chk("mask_width", rd, 32'h3FFF_FFFF);
        bus_wr(3'd2, 32'h2);
        chk("mask_irq", 32'(irq), 32'h1);
        bus_wr(3'd1, 32'h5);
        bus_rd(3'd1, rd);
        chk("w1c_partial", rd, 32'h2);

        // Asynchronous reset while bit 5 is mid-count
        @(negedge clk);
        pin_in[5] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("arst_stable_c2", 32'(stable_out), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_stable_c3", 32'(stable_out), 32'h20);
        bus_rd(3'd1, rd);
        chk("arst_edge", rd, 32'h0);
        bus_rd(3'd2, rd);
        chk("arst_mask", rd, 32'h0);
        bus_rd(3'd3, rd);
        chk("arst_rise", rd, 32'h0);
        bus_rd(3'd4, rd);
        chk("arst_fall", rd, 32'h0);
        bus_rd(3'd5, rd);
        chk("arst_dblim", rd, 32'h0);
        bus_rd(3'd0, rd);
        chk("arst_data", rd, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
